// File: rtl/port_alloc_sched.sv
// Sequential allocate-or-deflect scheduler: one priority slot per clock.
// Ports: in_* batch handshake, out_* results handshake, deflect_cnt stat (PORT_ALLOC_DEFLECT_CNT_EN).
`ifndef NUM_PORT
`define NUM_PORT 4
`endif

module port_alloc_sched #(
  parameter int NUM_PORT = `NUM_PORT,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_PORT-1:0]          in_flit_vld,
  input  logic [NUM_PORT*NUM_PORT-1:0] in_req,
  input  logic [NUM_PORT-1:0]          in_avail,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PORT*NUM_PORT-1:0] out_alloc,
  output logic [NUM_PORT-1:0]          out_deflect,
  output logic                         out_err,
  output logic [CNT_W-1:0]             deflect_cnt
);

  localparam int KW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  typedef enum logic [1:0] {IDLE, ALLOC, DONE} state_t;

  state_t state, state_nxt;

  logic [KW-1:0]                k;
  logic [NUM_PORT-1:0]          vld_r;
  logic [NUM_PORT-1:0]          avail_r;
  logic [NUM_PORT*NUM_PORT-1:0] req_r;

  logic [NUM_PORT-1:0] slot_req;
  logic [NUM_PORT-1:0] temp;
  logic [NUM_PORT-1:0] grant;
  logic                dfl;
  logic                err_set;
  logic                last;
  logic                accept;

  function automatic logic [NUM_PORT-1:0] msb1(
    input logic [NUM_PORT-1:0] v
  );
    logic [NUM_PORT-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign last   = (k == KW'(NUM_PORT - 1));
  assign accept = (state == IDLE) && in_valid;

  // Current-slot decision: productive port first, else any free port.
  always_comb begin
    slot_req = req_r[k*NUM_PORT +: NUM_PORT];
    temp     = slot_req & avail_r;
    grant    = '0;
    dfl      = 1'b0;
    err_set  = 1'b0;
    if (vld_r[k]) begin
      if (|temp) begin
        grant = msb1(temp);
      end else if (|avail_r) begin
        grant = msb1(avail_r);
        dfl   = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = ALLOC;
      ALLOC:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      vld_r       <= '0;
      req_r       <= '0;
      avail_r     <= '0;
      out_alloc   <= '0;
      out_deflect <= '0;
      out_err     <= 1'b0;
    end else if (accept) begin
      k           <= '0;
      vld_r       <= in_flit_vld;
      req_r       <= in_req;
      avail_r     <= in_avail;
      out_alloc   <= '0;
      out_deflect <= '0;
      out_err     <= 1'b0;
    end else if (state == ALLOC) begin
      out_alloc[k*NUM_PORT +: NUM_PORT] <= grant;
      out_deflect[k] <= dfl;
      avail_r        <= avail_r & ~grant;
      if (err_set) out_err <= 1'b1;
      if (!last)   k <= k + 1'b1;
    end
  end

`ifdef PORT_ALLOC_DEFLECT_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state == ALLOC && dfl && !(&cnt_r)) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign deflect_cnt = cnt_r;
`else
  assign deflect_cnt = '0;
`endif

endmodule

// File: doc/port_alloc_sched.md
# port_alloc_sched

Sequential port-allocation scheduler for the bufferless deflection router. Accepts one batch of up to `NUM_PORT` flits, pre-sorted by priority (slot 0 oldest), plus the set of free output ports. It time-multiplexes a single allocate-or-deflect stage over the slots, one slot per clock, in place of a combinational cascade of allocators. It sits between the age-sort stage and the crossbar and returns per-slot grant vectors, deflect flags and an optional deflection statistic.

## Interface
- `NUM_PORT`, default `` `NUM_PORT `` (4): number of output ports, which is also the number of flit slots.
- `CNT_W`, default 16: width of the deflection counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  batch offered.
- `in_ready`  out  1  scheduler can accept a batch.
- `in_flit_vld`  in  NUM_PORT  bit i: slot i holds a flit.
- `in_req`  in  NUM_PORT*NUM_PORT  productive-port vector; slot i is `[i*NUM_PORT +: NUM_PORT]`.
- `in_avail`  in  NUM_PORT  output ports free this router cycle.
- `out_valid`  out  1  results ready.
- `out_ready`  in  1  consumer takes the results.
- `out_alloc`  out  NUM_PORT*NUM_PORT  one-hot (or zero) grant per slot, same slicing as `in_req`.
- `out_deflect`  out  NUM_PORT  bit i: slot i was granted a non-productive port.
- `out_err`  out  1  at least one valid slot found no free port.
- `deflect_cnt`  out  CNT_W  saturating count of deflections.

## Operation
- **FSM states:** IDLE, ALLOC, DONE. Reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: register `in_flit_vld`, `in_req` and `in_avail` into the working-avail register.
  - Clear `out_alloc`, `out_deflect` and `out_err`; set slot index k=0; go to ALLOC.
- **ALLOC:** one slot per cycle, always NUM_PORT cycles, including for invalid slots.
  - Invalid slot k: grant 0, deflect 0.
  - Valid slot k: compute temp = req[k] & avail.
  - If temp≠0: grant = highest set bit of temp; deflect=0.
  - Else if avail≠0: grant = highest set bit of avail; deflect=1.
  - Else: grant=0, deflect=0, set `out_err`.
  - Update avail ← avail & ~grant.
  - When k=NUM_PORT-1, go to DONE; otherwise k←k+1.
- **DONE:** `out_valid`=1.
  - On `out_ready`, go to IDLE.
  - `out_alloc`, `out_deflect` and `out_err` hold stable until the handshake and are not cleared by it.
- **Back-pressure:** `in_ready` is 0 in ALLOC and DONE, so at most one batch is in flight.
- **Grant invariant:** grant vectors are mutually exclusive across slots. A productive port is never taken by a lower-priority slot ahead of a higher-priority slot.
- **Reset:** `rst_n` low in any state forces IDLE immediately.
  - k=0; all result registers 0; `deflect_cnt`=0; an in-flight batch is discarded.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_alloc`=0, `out_deflect`=0, `out_err`=0, `deflect_cnt`=0.
- **Latency:** batch accepted at edge T; slots 0..NUM_PORT-1 resolve at edges T+1..T+NUM_PORT; `out_valid`=1 after edge T+NUM_PORT (4 cycles at default).
- **Throughput:** with `out_ready` held high, one batch per NUM_PORT+2 cycles.
- **Output registers:** all outputs come from registers except `in_ready` and `out_valid`, which decode the state register. No combinational path exists from inputs to outputs.
- **Intermediate results:** `out_alloc`/`out_deflect` change during ALLOC and are meaningful only while `out_valid`=1.

## Configuration
- **Macro:** `PORT_ALLOC_DEFLECT_CNT_EN`.
- **Defined:** `deflect_cnt` increments by 1 for each ALLOC cycle that sets a deflect bit. It saturates at all-ones and clears only on reset.
- **Undefined:** the counter logic is omitted; `deflect_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → `in_ready`=1, `out_valid`=0, all results and `deflect_cnt` 0.
- **Conflict and deflect:** `in_avail`=4'b1111, vld=4'b1111, req slots 0..3 = 0100, 0100, 0001, 0010.
  - `out_valid` rises exactly 4 cycles after acceptance.
  - alloc = 0100, 1000, 0001, 0010; `out_deflect`=4'b0010; `deflect_cnt`=1 (macro on) or 0 (macro off).
- **Port exhaustion:** `in_avail`=4'b0011, vld=4'b0111, all req=1000 → alloc = 0010, 0001, 0000; deflect=4'b0011; `out_err`=1.
- **Sparse slots:** vld=4'b0101, avail=4'b1111, req slot0=0001, slot2=0001 → alloc slot0=0001, slot2=1000, slots 1 and 3 = 0; deflect=4'b0100; latency still 4.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Raise `out_ready` → IDLE the next cycle, `in_ready`=1.
- **Reset mid-ALLOC:** pulse `rst_n` low at k=2 → immediate IDLE, results cleared, counter 0. A following batch completes normally.
